ps2_key_event_decoder: RTL and testbench



---
 rtl/ps2_key_event_decoder_if.sv | 22 ++
 rtl/ps2_key_event_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_decoder_if.sv
// Key-event stream between the decoder and its consumer (display, CPU MMIO).
// Latency: none, this is wiring only.
// Backpressure: the producer holds the head event stable until evt_valid & evt_ready.
// Ports: evt_valid/evt_ready handshake; evt_code, evt_ext, evt_release, evt_ascii payload.
interface ps2_key_event_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic [7:0] evt_ascii;

    modport master (
        output evt_valid, evt_code, evt_ext, evt_release, evt_ascii,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_code, evt_ext, evt_release, evt_ascii,
        output evt_ready
    );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// Decodes PS/2 set-2 bytes (E0/F0 prefixes) into key events with ASCII, held-key and shift/caps tracking.
// Latency: a final byte is consumed in IDLE; its event enters the FIFO on the next clock; 1 byte per 3 cycles.
// Backpressure: events queue in a FIFO_DEPTH FIFO; a push into a full FIFO without a same-cycle pop is
//               dropped and flags evt_overflow. Byte intake never stalls.
// Ports: clk, reset (sync, active-high); in_data/in_ready/nextdata_n to the PS/2 receiver;
//        evt (master) event stream; press_cnt, shift_on, caps_on, evt_overflow status.
module ps2_key_event_decoder #(
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_ready,
    output logic                     nextdata_n,
    ps2_key_event_decoder_if.master  evt,
    output logic [CNT_W-1:0]         press_cnt,
    output logic                     shift_on,
    output logic                     caps_on,
    output logic                     evt_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } evt_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t       state;
    logic         ext_flag;
    logic         brk_flag;
    logic [255:0] held_std;
    logic [255:0] held_ext;
    logic         push_vld;
    evt_t         push_dat;

    evt_t         mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         fifo_empty;
    logic         fifo_full;
    logic         do_pop;
    logic         do_push;
    evt_t         head;

    logic         cur_held;
    logic [7:0]   cur_ascii;

    // Set-2 scan code to ASCII. Only letters are case-sensitive.
    function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic ext, input logic upper);
        logic [7:0] r;
        logic [4:0] idx;
        logic       is_letter;
        r         = 8'h00;
        idx       = 5'd0;
        is_letter = 1'b1;
        case (c)
            8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
            8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
            8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
            8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
            8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
            8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
            8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
            default: is_letter = 1'b0;
        endcase
        if (is_letter) begin
            r = upper ? (8'h41 + {3'b000, idx}) : (8'h61 + {3'b000, idx});
        end else begin
            case (c)
                8'h45: r = 8'h30;  8'h16: r = 8'h31;  8'h1E: r = 8'h32;  8'h26: r = 8'h33;
                8'h25: r = 8'h34;  8'h2E: r = 8'h35;  8'h36: r = 8'h36;  8'h3D: r = 8'h37;
                8'h3E: r = 8'h38;  8'h46: r = 8'h39;
                8'h29: r = 8'h20;
                8'h5A: r = 8'h0D;
                8'h66: r = 8'h08;
                default: r = 8'h00;
            endcase
        end
        if (ext) begin
            r = 8'h00;
        end
        return r;
    endfunction

    assign shift_on  = held_std[8'h12] | held_std[8'h59];
    assign cur_held  = ext_flag ? held_ext[in_data] : held_std[in_data];
    // Uses the modifier state from before this byte's own held/caps update.
    assign cur_ascii = to_ascii(in_data, ext_flag, shift_on ^ caps_on);

    // Byte FSM: consume in IDLE, one-cycle pop strobe in ACK, settle in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            nextdata_n <= 1'b1;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            held_std   <= '0;
            held_ext   <= '0;
            press_cnt  <= '0;
            caps_on    <= 1'b0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
        end else begin
            push_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_ready) begin
                        state      <= S_ACK;
                        nextdata_n <= 1'b0;
                        case (in_data)
                            8'hE0: ext_flag <= 1'b1;
                            8'hF0: brk_flag <= 1'b1;
                            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: begin
                                ext_flag <= 1'b0;
                                brk_flag <= 1'b0;
                            end
                            default: begin
                                ext_flag      <= 1'b0;
                                brk_flag      <= 1'b0;
                                push_dat.code <= in_data;
                                push_dat.ext  <= ext_flag;
                                push_dat.rel  <= brk_flag;
                                push_dat.ascii <= cur_ascii;
                                if (brk_flag) begin
                                    // Breaks always pass, even for keys we never saw pressed.
                                    if (ext_flag) held_ext[in_data] <= 1'b0;
                                    else          held_std[in_data] <= 1'b0;
                                    push_vld <= 1'b1;
                                end else if (!((FILTER_REPEAT != 0) && cur_held)) begin
                                    if (ext_flag) held_ext[in_data] <= 1'b1;
                                    else          held_std[in_data] <= 1'b1;
                                    push_vld  <= 1'b1;
                                    press_cnt <= press_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                                    if (!ext_flag && (in_data == 8'h58)) begin
                                        caps_on <= ~caps_on;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_ACK: begin
                    nextdata_n <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: state <= S_IDLE;
                default: begin
                    nextdata_n <= 1'b1;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Event FIFO: extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop     = !fifo_empty && evt.evt_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still take the push.
    assign do_push    = push_vld && (!fifo_full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (push_vld && fifo_full && !do_pop) begin
                evt_overflow <= 1'b1;
            end
        end
    end

    assign head            = mem[rd_ptr[AW-1:0]];
    assign evt.evt_valid   = !fifo_empty;
    assign evt.evt_code    = head.code;
    assign evt.evt_ext     = head.ext;
    assign evt.evt_release = head.rel;
    assign evt.evt_ascii   = head.ascii;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder with an in-order event scoreboard.
// A second instance with repeat filtering off checks the unfiltered event count.
module tb_ps2_key_event_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data, in_data2;
    logic       in_ready, in_ready2;
    logic       nextdata_n, nextdata_n2;
    logic [7:0] press_cnt, press_cnt2;
    logic       shift_on, shift2, caps_on, caps2, evt_overflow, ovf2;

    ps2_key_event_decoder_if ev();
    ps2_key_event_decoder_if ev2();
    assign ev2.evt_ready = 1'b1;

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .CNT_W(8), .FILTER_REPEAT(1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_ready(in_ready),
        .nextdata_n(nextdata_n), .evt(ev.master), .press_cnt(press_cnt),
        .shift_on(shift_on), .caps_on(caps_on), .evt_overflow(evt_overflow)
    );

    ps2_key_event_decoder #(.FIFO_DEPTH(4), .CNT_W(8), .FILTER_REPEAT(0)) dut_nf (
        .clk(clk), .reset(reset), .in_data(in_data2), .in_ready(in_ready2),
        .nextdata_n(nextdata_n2), .evt(ev2.master), .press_cnt(press_cnt2),
        .shift_on(shift2), .caps_on(caps2), .evt_overflow(ovf2)
    );

    always #5 clk = ~clk;

    typedef logic [17:0] exp_t;   // {code, ext, release, ascii}
    exp_t exp_q[$];

    int   total = 0;
    int   bad = 0;
    int   low_cycles = 0;
    int   falls = 0;
    int   nf_events = 0;
    logic prev_nd = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Negedge sampling: pop-strobe shape, unfiltered event count, scoreboard.
    task automatic sample();
        exp_t e;
        exp_t got;
        if (nextdata_n === 1'b0) begin
            low_cycles++;
            if (prev_nd === 1'b1) falls++;
        end
        prev_nd = nextdata_n;
        if (ev2.evt_valid === 1'b1) nf_events++;
        if (ev.evt_valid === 1'b1 && ev.evt_ready === 1'b1) begin
            e = 'x;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            got = {ev.evt_code, ev.evt_ext, ev.evt_release, ev.evt_ascii};
            total++;
            assert (got === e) else begin
                bad++;
                $error("FAIL event: got %05h want %05h", got, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int which, input logic [7:0] b);
        logic got;
        got = 1'b0;
        if (which == 0) begin in_data = b;  in_ready = 1'b1;  end
        else            begin in_data2 = b; in_ready2 = 1'b1; end
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if ((which == 0 ? nextdata_n : nextdata_n2) === 1'b0) got = 1'b1;
        end
        total++;
        assert (got) else begin
            bad++;
            $error("FAIL pop_timeout: got no strobe want strobe for byte %02h", b);
        end
        // ready stays high through ACK; it drops once the FSM is in WAIT
        tick();
        if (which == 0) in_ready = 1'b0;
        else            in_ready2 = 1'b0;
    endtask

    task automatic expect_evt(input logic [7:0] c, input logic x, input logic r, input logic [7:0] a);
        exp_q.push_back({c, x, r, a});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (exp_q.size() != 0 || ev.evt_valid === 1'b1); i++) begin
            tick();
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    int lc0, fc0;

    initial begin
        reset = 1'b1;
        in_data = 8'h00; in_ready = 1'b0;
        in_data2 = 8'h00; in_ready2 = 1'b0;
        ev.evt_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_evt_valid", ev.evt_valid, 0);
        chk("rst_press_cnt", press_cnt, 0);
        chk("rst_shift", shift_on, 0);
        chk("rst_caps", caps_on, 0);
        chk("rst_ovf", evt_overflow, 0);
        chk("rst_code", ev.evt_code, 0);
        chk("rst_ascii", ev.evt_ascii, 0);

        // Make/break of 'a' and pop-strobe shape
        ev.evt_ready = 1'b1;
        lc0 = low_cycles; fc0 = falls;
        expect_evt(8'h1C, 0, 0, 8'h61); send(0, 8'h1C);
        send(0, 8'hF0);
        expect_evt(8'h1C, 0, 1, 8'h61); send(0, 8'h1C);
        wait_drain();
        chk("t1_press", press_cnt, 1);
        chk("t1_pulses", falls - fc0, 3);
        chk("t1_low_cycles", low_cycles - lc0, 3);

        // Shift and caps
        expect_evt(8'h12, 0, 0, 8'h00); send(0, 8'h12);
        chk("t2_shift_held", shift_on, 1);
        expect_evt(8'h1C, 0, 0, 8'h41); send(0, 8'h1C);
        send(0, 8'hF0); expect_evt(8'h1C, 0, 1, 8'h41); send(0, 8'h1C);
        send(0, 8'hF0); expect_evt(8'h12, 0, 1, 8'h00); send(0, 8'h12);
        expect_evt(8'h58, 0, 0, 8'h00); send(0, 8'h58);
        send(0, 8'hF0); expect_evt(8'h58, 0, 1, 8'h00); send(0, 8'h58);
        expect_evt(8'h1C, 0, 0, 8'h41); send(0, 8'h1C);
        wait_drain();
        chk("t2_caps", caps_on, 1);
        chk("t2_shift", shift_on, 0);
        chk("t2_press", press_cnt, 5);

        // Repeat filtering (1C is still held from above)
        send(0, 8'hF0); expect_evt(8'h1C, 0, 1, 8'h41); send(0, 8'h1C);
        expect_evt(8'h1C, 0, 0, 8'h41); send(0, 8'h1C);
        send(0, 8'h1C);
        send(0, 8'h1C);
        send(0, 8'hF0); expect_evt(8'h1C, 0, 1, 8'h41); send(0, 8'h1C);
        wait_drain();
        chk("t3_press", press_cnt, 6);

        send(1, 8'h1C); send(1, 8'h1C); send(1, 8'h1C);
        send(1, 8'hF0); send(1, 8'h1C);
        repeat (4) tick();
        chk("t3_nf_events", nf_events, 4);
        chk("t3_nf_press", press_cnt2, 3);
        chk("t3_nf_flags", {shift2, caps2, ovf2}, 0);

        // Extended codes, discards, special ASCII
        send(0, 8'hE0); expect_evt(8'h75, 1, 0, 8'h00); send(0, 8'h75);
        send(0, 8'hE0); send(0, 8'hF0); expect_evt(8'h75, 1, 1, 8'h00); send(0, 8'h75);
        expect_evt(8'h75, 0, 0, 8'h00); send(0, 8'h75);
        send(0, 8'hAA);
        send(0, 8'hE0); send(0, 8'hFA); expect_evt(8'h1C, 0, 0, 8'h41); send(0, 8'h1C);
        expect_evt(8'h45, 0, 0, 8'h30); send(0, 8'h45);
        expect_evt(8'h29, 0, 0, 8'h20); send(0, 8'h29);
        expect_evt(8'h5A, 0, 0, 8'h0D); send(0, 8'h5A);
        expect_evt(8'h66, 0, 0, 8'h08); send(0, 8'h66);
        expect_evt(8'h1A, 0, 0, 8'h5A); send(0, 8'h1A);
        wait_drain();
        chk("t4_press", press_cnt, 14);

        // Overflow: 6 makes into a depth-4 FIFO with no consumer
        ev.evt_ready = 1'b0;
        expect_evt(8'h15, 0, 0, 8'h51); send(0, 8'h15);
        expect_evt(8'h1D, 0, 0, 8'h57); send(0, 8'h1D);
        expect_evt(8'h24, 0, 0, 8'h45); send(0, 8'h24);
        expect_evt(8'h2D, 0, 0, 8'h52); send(0, 8'h2D);
        chk("t5_ovf_not_yet", evt_overflow, 0);
        send(0, 8'h2C);
        send(0, 8'h35);
        chk("t5_ovf", evt_overflow, 1);
        chk("t5_press", press_cnt, 20);
        chk("t5_valid", ev.evt_valid, 1);
        repeat (3) tick();
        chk("t5_head_stable", ev.evt_code, 8'h15);
        ev.evt_ready = 1'b1;
        wait_drain();
        chk("t5_ovf_sticky", evt_overflow, 1);

        // Reset mid-prefix
        send(0, 8'hE0);
        send(0, 8'hF0);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("t6_press", press_cnt, 0);
        chk("t6_caps", caps_on, 0);
        chk("t6_ovf", evt_overflow, 0);
        chk("t6_valid", ev.evt_valid, 0);
        expect_evt(8'h1C, 0, 0, 8'h61); send(0, 8'h1C);
        wait_drain();
        chk("t6_press_after", press_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
